// File: rtl/gobou_ctrl_mac_pkg.sv
// Shared types and defaults for the gobou MAC controller: FSM encoding,
// delay-line tag layout and the default layer-counter width.
package gobou_ctrl_mac_pkg;

  localparam int unsigned GOBOU_LWIDTH = 10;
  localparam int unsigned TAG_W        = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Tags travelling alongside the accumulator latency
  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } tag_t;

endpackage

// File: rtl/gobou_ctrl_mac_if.sv
// Handshake bundle between the layer sequencer and the MAC controller.
interface gobou_ctrl_mac_if
  import gobou_ctrl_mac_pkg::*;
#(
  parameter int unsigned LWIDTH = GOBOU_LWIDTH
);

  logic              in_begin;
  logic              in_valid;
  logic [LWIDTH-1:0] n_in;
  logic [LWIDTH-1:0] n_out;
  logic              mac_oe;
  logic              acc_clr;
  logic              out_begin;
  logic              out_valid;
  logic              out_end;
  logic              busy;

  modport master (
    output in_begin, in_valid, n_in, n_out,
    input  mac_oe, acc_clr, out_begin, out_valid, out_end, busy
  );

  modport slave (
    input  in_begin, in_valid, n_in, n_out,
    output mac_oe, acc_clr, out_begin, out_valid, out_end, busy
  );

endinterface

// File: rtl/gobou_ctrl_mac_delay.sv
// MAC_LAT-stage shift register carrying valid/begin/end tags; inj is ORed
// straight into the final stage for pulses that bypass the latency.
module gobou_ctrl_delay
  import gobou_ctrl_mac_pkg::*;
#(
  parameter int unsigned MAC_LAT = 2
) (
  input  logic clk,
  input  logic xrst,
  input  tag_t din,
  input  tag_t inj,
  output tag_t dout
);

  localparam int unsigned SW = TAG_W * MAC_LAT;

  logic [SW-1:0] sr_q;
  logic [SW-1:0] inj_w;

  assign inj_w = SW'(inj) << (TAG_W * (MAC_LAT - 1));

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      sr_q <= '0;
    end else begin
      sr_q <= SW'({sr_q, din}) | inj_w;
    end
  end

  assign dout = tag_t'(sr_q[SW-1 -: TAG_W]);

endmodule

// File: rtl/gobou_ctrl_mac.sv
// MAC-stage controller: sequences beats/neurons of a layer, drives the MAC
// enables and emits per-neuron completion pulses after the MAC latency.
// Optional GOBOU_CTRL_MAC_PERF_EN adds a busy-cycle counter port.
module gobou_ctrl_mac
  import gobou_ctrl_mac_pkg::*;
#(
  parameter int unsigned LWIDTH  = GOBOU_LWIDTH,
  parameter int unsigned MAC_LAT = 2
) (
  input  logic            clk,
  input  logic            xrst,
  gobou_ctrl_mac_if.slave bus
`ifdef GOBOU_CTRL_MAC_PERF_EN
  ,
  output logic [31:0]     perf_cycles
`endif
);

  state_e            state_q, state_d;
  logic [LWIDTH-1:0] n_in_q, n_in_d, n_out_q, n_out_d;
  logic [LWIDTH-1:0] beat_q, beat_d, neur_q, neur_d;
  logic              mac_oe_q, mac_oe_d, acc_clr_q, acc_clr_d, busy_q, busy_d;
  tag_t              tag_q, tag_d, dly_out, inj_c;
  logic              step_c, beat_last_c, neur_last_c, dims_ok_c, accept_c, zero_c;

  assign step_c      = (state_q == ST_ACC) && bus.in_valid;
  assign beat_last_c = (beat_q == n_in_q - LWIDTH'(1));
  assign neur_last_c = (neur_q == n_out_q - LWIDTH'(1));
  assign dims_ok_c   = (bus.n_in != '0) && (bus.n_out != '0);
  assign accept_c    = (state_q == ST_IDLE) && bus.in_begin && dims_ok_c;
  assign zero_c      = (state_q == ST_IDLE) && bus.in_begin && !dims_ok_c;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept_c) state_d = ST_ACC;
      ST_ACC:   if (step_c && beat_last_c && neur_last_c) state_d = ST_DRAIN;
      ST_DRAIN: if (dly_out.last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mac_oe_d    = step_c;
    acc_clr_d   = step_c && (beat_q == '0);
    tag_d.vld   = step_c && beat_last_c;
    tag_d.first = step_c && beat_last_c && (neur_q == '0);
    tag_d.last  = step_c && beat_last_c && neur_last_c;
    inj_c.vld   = 1'b0;
    inj_c.first = zero_c;
    inj_c.last  = zero_c;
    n_in_d      = n_in_q;
    n_out_d     = n_out_q;
    beat_d      = beat_q;
    neur_d      = neur_q;
    busy_d      = busy_q;
    if (accept_c) begin
      n_in_d  = bus.n_in;
      n_out_d = bus.n_out;
      beat_d  = '0;
      neur_d  = '0;
      busy_d  = 1'b1;
    end else if (step_c) begin
      if (beat_last_c) begin
        beat_d = '0;
        neur_d = neur_last_c ? '0 : neur_q + LWIDTH'(1);
      end else begin
        beat_d = beat_q + LWIDTH'(1);
      end
    end
    // busy covers the out_end cycle itself, then drops
    if ((state_q == ST_DRAIN) && dly_out.last) busy_d = 1'b0;
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      n_in_q    <= '0;
      n_out_q   <= '0;
      beat_q    <= '0;
      neur_q    <= '0;
      mac_oe_q  <= 1'b0;
      acc_clr_q <= 1'b0;
      busy_q    <= 1'b0;
      tag_q     <= '0;
    end else begin
      n_in_q    <= n_in_d;
      n_out_q   <= n_out_d;
      beat_q    <= beat_d;
      neur_q    <= neur_d;
      mac_oe_q  <= mac_oe_d;
      acc_clr_q <= acc_clr_d;
      busy_q    <= busy_d;
      tag_q     <= tag_d;
    end
  end

  // tag_q lines up with mac_oe, so the line adds exactly MAC_LAT cycles
  gobou_ctrl_delay #(.MAC_LAT(MAC_LAT)) u_delay (
    .clk  (clk),
    .xrst (xrst),
    .din  (tag_q),
    .inj  (inj_c),
    .dout (dly_out)
  );

  assign bus.mac_oe    = mac_oe_q;
  assign bus.acc_clr   = acc_clr_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = dly_out.vld;
  assign bus.out_begin = dly_out.first;
  assign bus.out_end   = dly_out.last;

`ifdef GOBOU_CTRL_MAC_PERF_EN
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      perf_cycles <= '0;
    end else if (accept_c) begin
      perf_cycles <= '0;
    end else if (busy_q) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gobou_ctrl_mac.sv
// Scoreboard bench for gobou_ctrl_mac: a behavioural model queues expected
// mac_oe/out_* events per cycle; a negedge monitor pops and compares them.
module tb_gobou_ctrl_mac;

  localparam int unsigned LW      = 10;
  localparam int unsigned MAC_LAT = 2;

  typedef struct {int cyc; bit clr;} mac_ev_t;
  typedef struct {int cyc; bit v; bit b; bit e;} out_ev_t;

  logic clk;
  logic xrst;
  int   cyc;
  int   checks;
  int   failures;
  int   busy_cnt;
  int   drv_cyc;
  int   cb, cl;
  int   m_st, m_ni, m_no, m_beat, m_neur;
  mac_ev_t mac_q[$];
  out_ev_t out_q[$];
`ifdef GOBOU_CTRL_MAC_PERF_EN
  logic [31:0] perf_cycles;
`endif

  gobou_ctrl_mac_if #(.LWIDTH(LW)) bus ();

  gobou_ctrl_mac #(.LWIDTH(LW), .MAC_LAT(MAC_LAT)) dut (
    .clk  (clk),
    .xrst (xrst),
    .bus  (bus)
`ifdef GOBOU_CTRL_MAC_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // One cycle of stimulus plus the expected consequences
  task automatic drive(input bit ib, input bit iv, input int ni, input int no);
    @(negedge clk);
    bus.in_begin = ib;
    bus.in_valid = iv;
    bus.n_in     = LW'(ni);
    bus.n_out    = LW'(no);
    drv_cyc      = cyc;
    if (m_st == 0 && ib) begin
      if (ni != 0 && no != 0) begin
        m_ni = ni; m_no = no; m_beat = 0; m_neur = 0; m_st = 1;
      end else begin
        out_q.push_back('{cyc + 1, 1'b0, 1'b1, 1'b1});
      end
    end else if (m_st == 1 && iv) begin
      mac_q.push_back('{cyc + 1, m_beat == 0});
      if (m_beat == m_ni - 1) begin
        out_q.push_back('{cyc + 1 + int'(MAC_LAT), 1'b1, m_neur == 0, m_neur == m_no - 1});
        m_beat = 0;
        if (m_neur == m_no - 1) m_st = 2;
        m_neur++;
      end else begin
        m_beat++;
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      drive(0, 0, 0, 0);
      n++;
    end while ((bus.busy || mac_q.size() != 0 || out_q.size() != 0) && n < 60);
    repeat (2) drive(0, 0, 0, 0);
    m_st = 0;
    chk("mac_q_left", mac_q.size(), 0);
    chk("out_q_left", out_q.size(), 0);
    chk("busy_end", bus.busy, 0);
  endtask

  always @(negedge clk) begin
    if (xrst) begin
      if (bus.busy) busy_cnt++;
      if (mac_q.size() != 0 && mac_q[0].cyc < cyc) begin
        chk("mac_missing", 0, 1);
        void'(mac_q.pop_front());
      end
      if (out_q.size() != 0 && out_q[0].cyc < cyc) begin
        chk("out_missing", 0, 1);
        void'(out_q.pop_front());
      end
      if (bus.mac_oe) begin
        if (mac_q.size() == 0) chk("mac_unexpected", 1, 0);
        else begin
          mac_ev_t e;
          e = mac_q.pop_front();
          chk("mac_oe_cyc", cyc, e.cyc);
          chk("acc_clr", bus.acc_clr, e.clr);
        end
      end else if (bus.acc_clr) begin
        chk("acc_clr_alone", 1, 0);
      end
      if (bus.out_valid || bus.out_begin || bus.out_end) begin
        if (out_q.size() == 0) chk("out_unexpected", 1, 0);
        else begin
          out_ev_t o;
          o = out_q.pop_front();
          chk("out_cyc", cyc, o.cyc);
          chk("out_valid", bus.out_valid, o.v);
          chk("out_begin", bus.out_begin, o.b);
          chk("out_end", bus.out_end, o.e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; checks = 0; failures = 0; busy_cnt = 0; m_st = 0;
    m_ni = 0; m_no = 0; m_beat = 0; m_neur = 0; drv_cyc = 0; cb = 0; cl = 0;
    xrst = 1'b0;
    bus.in_begin = 1'b0; bus.in_valid = 1'b0; bus.n_in = '0; bus.n_out = '0;
    repeat (3) @(negedge clk);
    chk("rst_mac_oe", bus.mac_oe, 0);
    chk("rst_acc_clr", bus.acc_clr, 0);
    chk("rst_out_begin", bus.out_begin, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_end", bus.out_end, 0);
    chk("rst_busy", bus.busy, 0);
    xrst = 1'b1;
    drive(0, 0, 0, 0);

    // n_in=3, n_out=2, continuous beats
    busy_cnt = 0;
    drive(1, 0, 3, 2);
    cb = drv_cyc;
    for (int i = 0; i < 6; i++) drive(0, 1, 3, 2);
    cl = drv_cyc;
    wait_idle();
    chk("busy_cycles_3x2", busy_cnt, cl + 1 + int'(MAC_LAT) - cb);
`ifdef GOBOU_CTRL_MAC_PERF_EN
    chk("perf_cycles", perf_cycles, cl + 1 + int'(MAC_LAT) - cb);
`endif

    // n_in=4, n_out=1, 1-on/1-off beats
    drive(1, 0, 4, 1);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 4, 1);
      drive(0, 0, 4, 1);
    end
    wait_idle();

    // n_in=1, n_out=5: every beat clears and completes a neuron
    drive(1, 0, 1, 5);
    for (int i = 0; i < 5; i++) drive(0, 1, 1, 5);
    wait_idle();

    // degenerate layers: zero outputs, then zero inputs
    busy_cnt = 0;
    drive(1, 1, 3, 0);
    wait_idle();
    drive(1, 1, 0, 4);
    wait_idle();
    chk("busy_zero_layers", busy_cnt, 0);

    // second in_begin mid-layer must not re-latch sizes
    drive(1, 0, 2, 2);
    drive(0, 1, 2, 2);
    drive(1, 1, 5, 5);
    drive(0, 1, 2, 2);
    drive(0, 1, 2, 2);
    wait_idle();

    // reset mid-ACC with a completion pulse still in flight
    drive(1, 0, 3, 2);
    for (int i = 0; i < 4; i++) drive(0, 1, 3, 2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    xrst = 1'b0;
    #1;
    mac_q.delete();
    out_q.delete();
    m_st = 0;
    chk("mid_rst_mac_oe", bus.mac_oe, 0);
    chk("mid_rst_acc_clr", bus.acc_clr, 0);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_out_end", bus.out_end, 0);
    chk("mid_rst_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    xrst = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) drive(0, 1, 3, 2);
    chk("post_rst_busy", busy_cnt, 0);
    wait_idle();

    // recovery layer after reset
    drive(1, 0, 2, 1);
    drive(0, 1, 2, 1);
    drive(0, 1, 2, 1);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
